// File: rtl/kmeans_pkg.sv
// Shared constants and types for the k-means point datapath.
// Points are packed as COORD_NUM coordinates of CORD_W bits each, with
// coordinate k at bits [(k+1)*CORD_W-1 : k*CORD_W]. Per-cluster accumulated
// sums use ACCUM_CORD_W bits per coordinate with the same packing order.
package kmeans_pkg;

  localparam int COORD_NUM    = 7;
  localparam int CORD_W       = 13;
  localparam int ACCUM_CORD_W = 22;
  localparam int COUNT_W      = 10;
  localparam int DATA_W       = COORD_NUM * CORD_W;
  localparam int ACCUM_W      = COORD_NUM * ACCUM_CORD_W;
  localparam int CORD_MAX     = 8191;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } cdiv_state_t;

  typedef logic [CORD_W-1:0]       cord_t;
  typedef logic [ACCUM_CORD_W-1:0] accum_cord_t;

endpackage

// File: rtl/centroid_divider_div_step.sv
// One restoring-division step (combinational).
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits.
// Ports:
//   rem_in   - partial remainder from the previous step (always < divisor)
//   din      - next dividend bit, MSB first
//   divisor  - unsigned member count (non-zero while dividing)
//   rem_out  - updated partial remainder
//   qbit     - quotient bit produced by this step
module div_step
  import kmeans_pkg::*;
(
  input  logic [COUNT_W-1:0] rem_in,
  input  logic               din,
  input  logic [COUNT_W-1:0] divisor,
  output logic [COUNT_W-1:0] rem_out,
  output logic               qbit
);

  logic [COUNT_W:0] trial;
  logic [COUNT_W:0] diff;

  always_comb begin
    trial = {rem_in, din};
    diff  = trial - {1'b0, divisor};
    qbit  = (trial >= {1'b0, divisor});
    // Either branch result is below the divisor, so the top bit is always 0.
    rem_out = qbit ? diff[COUNT_W-1:0] : trial[COUNT_W-1:0];
  end

endmodule

// File: rtl/centroid_divider.sv
// Centroid divider: rebuilds a packed centroid point from per-coordinate
// accumulated sums and a member count, new_coord = accum / count, using a
// sequential restoring divider (one quotient bit per cycle, one coordinate
// at a time). Quotients above CORD_MAX saturate to CORD_MAX. A zero count
// returns prev_centroid unchanged.
// Optional build macro: CENTROID_DIV_ROUND_EN selects round-to-nearest
// (q+1 when 2*rem >= count, saturation after rounding); undefined gives floor.
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset
//   start         - request pulse, sampled only in IDLE
//   accum_in      - packed coordinate sums (ACCUM_W)
//   count_in      - unsigned member count
//   prev_centroid - centroid returned when count_in == 0
//   busy          - high while dividing
//   done          - one-cycle pulse, centroid_out valid from this cycle
//   centroid_out  - packed result, held until the next done
module centroid_divider
  import kmeans_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ACCUM_W-1:0] accum_in,
  input  logic [COUNT_W-1:0] count_in,
  input  logic [DATA_W-1:0]  prev_centroid,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  centroid_out
);

  localparam logic [4:0] BIT_TOP   = 5'(ACCUM_CORD_W - 1);
  localparam logic [2:0] COORD_TOP = 3'(COORD_NUM - 1);

  cdiv_state_t        state, state_next;
  logic [ACCUM_W-1:0] accum_r;
  logic [COUNT_W-1:0] count_r;
  logic [2:0]         coord_idx;
  logic [4:0]         bit_idx;
  logic [COUNT_W-1:0] rem_r;
  accum_cord_t        quot_r;
  logic [DATA_W-1:0]  slots_r;

  accum_cord_t          cur_sum;
  logic [COUNT_W-1:0]   step_rem;
  logic                 step_q;
  accum_cord_t          quot_next;
  logic [ACCUM_CORD_W:0] quot_ext;
  cord_t                slot_val;
  logic [DATA_W-1:0]    slots_next;
  logic                 coord_last_bit;

  function automatic cord_t sat_cord(input logic [ACCUM_CORD_W:0] q);
    if (q > (ACCUM_CORD_W+1)'(CORD_MAX))
      return cord_t'(CORD_MAX);
    else
      return q[CORD_W-1:0];
  endfunction

`ifdef CENTROID_DIV_ROUND_EN
  function automatic logic [ACCUM_CORD_W:0] round_q(input accum_cord_t q,
                                                    input logic [COUNT_W-1:0] r,
                                                    input logic [COUNT_W-1:0] d);
    if ({r, 1'b0} >= {1'b0, d})
      return {1'b0, q} + (ACCUM_CORD_W+1)'(1);
    else
      return {1'b0, q};
  endfunction
`endif

  assign cur_sum = accum_r[int'(coord_idx)*ACCUM_CORD_W +: ACCUM_CORD_W];

  div_step u_div_step (
    .rem_in  (rem_r),
    .din     (cur_sum[bit_idx]),
    .divisor (count_r),
    .rem_out (step_rem),
    .qbit    (step_q)
  );

  // Quotient bits enter MSB first, so the finished quotient appears after
  // the bit_idx == 0 step as the shifted word.
  always_comb begin
    quot_next      = {quot_r[ACCUM_CORD_W-2:0], step_q};
    coord_last_bit = (bit_idx == 5'd0);
`ifdef CENTROID_DIV_ROUND_EN
    quot_ext = round_q(quot_next, step_rem, count_r);
`else
    quot_ext = {1'b0, quot_next};
`endif
    slot_val   = sat_cord(quot_ext);
    slots_next = slots_r;
    slots_next[int'(coord_idx)*CORD_W +: CORD_W] = slot_val;
  end

  // FSM next state and outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = (count_in == '0) ? DONE : DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (coord_last_bit && (coord_idx == COORD_TOP))
          state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Working registers and result. centroid_out is loaded on the edge that
  // enters DONE so it is already valid in the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      accum_r      <= '0;
      count_r      <= '0;
      coord_idx    <= '0;
      bit_idx      <= '0;
      rem_r        <= '0;
      quot_r       <= '0;
      slots_r      <= '0;
      centroid_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            accum_r   <= accum_in;
            count_r   <= count_in;
            coord_idx <= '0;
            bit_idx   <= BIT_TOP;
            rem_r     <= '0;
            quot_r    <= '0;
            slots_r   <= '0;
            // Zero count: the previous centroid is the result; capture it
            // straight into the output register.
            if (count_in == '0)
              centroid_out <= prev_centroid;
          end
        end
        DIV: begin
          quot_r <= quot_next;
          if (coord_last_bit) begin
            slots_r   <= slots_next;
            rem_r     <= '0;
            bit_idx   <= BIT_TOP;
            coord_idx <= coord_idx + 3'd1;
            if (coord_idx == COORD_TOP)
              centroid_out <= slots_next;
          end else begin
            rem_r   <= step_rem;
            bit_idx <= bit_idx - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_divider.sv
module tb_centroid_divider;
  import kmeans_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ACCUM_W-1:0] accum_in;
  logic [COUNT_W-1:0] count_in;
  logic [DATA_W-1:0]  prev_centroid;
  logic               busy;
  logic               done;
  logic [DATA_W-1:0]  centroid_out;

  int tests = 0;
  int fails = 0;
  logic [DATA_W-1:0] exp_q[$];

  centroid_divider dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .accum_in      (accum_in),
    .count_in      (count_in),
    .prev_centroid (prev_centroid),
    .busy          (busy),
    .done          (done),
    .centroid_out  (centroid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] model(input logic [ACCUM_W-1:0] a,
                                              input logic [COUNT_W-1:0] c,
                                              input logic [DATA_W-1:0] p);
    logic [DATA_W-1:0] r;
    longint unsigned s, q, m, d;
    r = '0;
    if (c == '0) return p;
    d = 64'(c);
    for (int i = 0; i < COORD_NUM; i++) begin
      s = 64'(a[i*ACCUM_CORD_W +: ACCUM_CORD_W]);
      q = s / d;
      m = s % d;
`ifdef CENTROID_DIV_ROUND_EN
      if (2 * m >= d) q = q + 1;
`endif
      if (q > 64'(CORD_MAX)) q = 64'(CORD_MAX);
      r[i*CORD_W +: CORD_W] = q[CORD_W-1:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Drives one request; returns just after the accepting edge T.
  task automatic launch(input logic [ACCUM_W-1:0] a, input logic [COUNT_W-1:0] c,
                        input logic [DATA_W-1:0] p, input bit push);
    @(negedge clk);
    accum_in      = a;
    count_in      = c;
    prev_centroid = p;
    start         = 1'b1;
    if (push) exp_q.push_back(model(a, c, p));
    @(posedge clk);
    #1;
    start         = 1'b0;
    accum_in      = ~a;
    count_in      = ~c;
    prev_centroid = ~p;
  endtask

  // Sample k is taken at the negedge just before edge T+k.
  task automatic run_wait(input string tag, input int exp_lat, input int exp_busy,
                          input int inject_k, output logic [DATA_W-1:0] got);
    int lat;
    int nbusy;
    logic [DATA_W-1:0] expv;
    lat   = 0;
    nbusy = 0;
    got   = '0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (inject_k == k) begin
        start    = 1'b1;
        accum_in = {COORD_NUM{22'h2AAAAA}};
        count_in = 10'd3;
      end else if (inject_k + 1 == k) begin
        start = 1'b0;
      end
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        got = centroid_out;
        break;
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, " busy cycles"}, 128'(nbusy), 128'(exp_busy));
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk({tag, " result"}, 128'(got), 128'(expv));
    @(negedge clk);
    chk({tag, " done single pulse"}, 128'(done), 128'(0));
    chk({tag, " result held"}, 128'(centroid_out), 128'(expv));
  endtask

  initial begin
    logic [ACCUM_W-1:0] a;
    logic [DATA_W-1:0]  got;
    int                 ndone;

    rst = 1'b1; start = 1'b0; accum_in = '0; count_in = '0; prev_centroid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset centroid_out", 128'(centroid_out), 128'(0));
    rst = 1'b0;

    // Exact division: 1000/10 = 100 everywhere
    launch({COORD_NUM{22'd1000}}, 10'd10, '0, 1'b1);
    run_wait("exact", 155, 154, 0, got);
    for (int i = 0; i < COORD_NUM; i++)
      chk("exact coord", 128'(got[i*CORD_W +: CORD_W]), 128'(100));

    // Truncation / rounding
    a = '0;
    a[0 +: 22]  = 22'd17;
    a[22 +: 22] = 22'd18;
    a[44 +: 22] = 22'd1000;
    launch(a, 10'd4, '0, 1'b1);
    run_wait("round", 155, 154, 0, got);
    chk("round coord0", 128'(got[0 +: 13]), 128'(4));
`ifdef CENTROID_DIV_ROUND_EN
    chk("round coord1", 128'(got[13 +: 13]), 128'(5));
`else
    chk("round coord1", 128'(got[13 +: 13]), 128'(4));
`endif
    chk("round coord2", 128'(got[26 +: 13]), 128'(250));

    // Zero count returns prev_centroid
    launch({COORD_NUM{22'h155555}}, 10'd0, 91'h123_4567_89AB_CDEF_0123_4567, 1'b1);
    run_wait("zero", 1, 0, 0, got);
    chk("zero prev", 128'(got), 128'(91'h123_4567_89AB_CDEF_0123_4567));

    // Saturation on coord6
    a = '0;
    for (int i = 0; i < 6; i++) a[i*22 +: 22] = 22'(5000 + i);
    a[132 +: 22] = 22'h3FFFFF;
    launch(a, 10'd1, '0, 1'b1);
    run_wait("sat", 155, 154, 0, got);
    chk("sat coord6", 128'(got[78 +: 13]), 128'(13'h1FFF));
    chk("sat coord5", 128'(got[65 +: 13]), 128'(5005));

    // Packing order: coord k = k+1
    for (int i = 0; i < COORD_NUM; i++) a[i*22 +: 22] = 22'(i + 1);
    launch(a, 10'd1, '0, 1'b1);
    run_wait("order", 155, 154, 0, got);
    for (int i = 0; i < COORD_NUM; i++)
      chk("order slot", 128'(got[i*CORD_W +: CORD_W]), 128'(i + 1));

    // Start during DIV is ignored
    for (int i = 0; i < COORD_NUM; i++) a[i*22 +: 22] = 22'(12345 * (i + 1));
    launch(a, 10'd37, '0, 1'b1);
    run_wait("ignored start", 155, 154, 50, got);
    @(negedge clk);
    chk("ignored start no restart", 128'(busy), 128'(0));

    // Reset abort at T+80
    launch({COORD_NUM{22'd777}}, 10'd7, '0, 1'b0);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 80) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", 128'(busy), 128'(0));
    chk("abort done", 128'(done), 128'(0));
    chk("abort centroid_out", 128'(centroid_out), 128'(0));
    ndone = 0;
    repeat (200) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort no done", 128'(ndone), 128'(0));
    launch({COORD_NUM{22'd777}}, 10'd7, '0, 1'b1);
    run_wait("after abort", 155, 154, 0, got);

    // Random operands including extreme counts
    for (int n = 0; n < 4; n++) begin
      logic [COUNT_W-1:0] c;
      for (int i = 0; i < COORD_NUM; i++) a[i*22 +: 22] = 22'($urandom);
      c = (n == 0) ? 10'd1023 : (n == 1) ? 10'd2 : 10'($urandom_range(1, 1023));
      launch(a, c, '0, 1'b1);
      run_wait("random", 155, 154, 0, got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
